// File: rtl/fp_div.sv
// ============================================================================
// Module      : fp_div
// Description : Iterative binary32 divider (restoring, one quotient bit per
//               clock, truncation rounding). Macro FP_DIV_SPECIAL_EN enables
//               zero/inf/NaN handling and exponent saturation/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        busy,
    output logic        done,
    output logic [31:0] ret
);

`ifdef FP_DIV_SPECIAL_EN
    localparam int EXP_W = 10;
`else
    // Without special handling the exponent wraps in 8 bits, so the upper
    // bits of the signed intermediate would never be observed.
    localparam int EXP_W = 8;
`endif

    localparam logic [4:0] C_ITER_LAST = 5'd24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [24:0]        r_quo;
    logic [4:0]         r_cnt;

    logic               w_ge;
    logic [24:0]        w_rem_sub;
    logic [24:0]        w_rem_sel;
    logic [24:0]        w_rem_nxt;
    logic [EXP_W-1:0]   w_exp_cap;
    logic [EXP_W-1:0]   w_exp_n;
    logic [22:0]        w_frac;
    logic [31:0]        w_ret_n;

`ifdef FP_DIV_SPECIAL_EN
    logic               r_nan;
    logic               r_a_zero;
    logic               r_b_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == 5'd0) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_exp_cap = EXP_W'(a0[30:23]) - EXP_W'(b0[30:23]) + EXP_W'(127);
        w_ge      = (r_rem >= {1'b0, r_mb});
        w_rem_sub = r_rem - {1'b0, r_mb};
        w_rem_sel = w_ge ? w_rem_sub : r_rem;
        // The kept remainder is always below mb, so the shift cannot overflow.
        w_rem_nxt = w_rem_sel << 1;
        w_exp_n   = r_quo[24] ? r_exp : r_exp - EXP_W'(1);
        w_frac    = r_quo[24] ? r_quo[23:1] : r_quo[22:0];
        w_ret_n   = {r_sign, w_exp_n[7:0], w_frac};
`ifdef FP_DIV_SPECIAL_EN
        if (r_nan) begin
            w_ret_n = 32'h7FC0_0000;
        end else if (r_a_zero) begin
            w_ret_n = {r_sign, 31'h0};
        end else if (r_b_zero) begin
            w_ret_n = {r_sign, 8'hFF, 23'h0};
        end else if ($signed(w_exp_n) >= $signed(10'd255)) begin
            w_ret_n = {r_sign, 8'hFF, 23'h0};
        end else if ($signed(w_exp_n) <= $signed(10'd0)) begin
            w_ret_n = {r_sign, 31'h0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            ret   <= 32'h0;
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_mb   <= 24'h0;
            r_rem  <= 25'h0;
            r_quo  <= 25'h0;
            r_cnt  <= 5'd0;
`ifdef FP_DIV_SPECIAL_EN
            r_nan    <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        r_sign <= a0[31] ^ b0[31];
                        r_exp  <= w_exp_cap;
                        r_mb   <= {1'b1, b0[22:0]};
                        r_rem  <= {2'b01, a0[22:0]};
                        r_quo  <= 25'h0;
                        r_cnt  <= C_ITER_LAST;
`ifdef FP_DIV_SPECIAL_EN
                        r_nan    <= (a0[30:23] == 8'hFF) || (b0[30:23] == 8'hFF);
                        r_a_zero <= (a0[30:23] == 8'h00);
                        r_b_zero <= (b0[30:23] == 8'h00);
`endif
                    end
                end
                S_DIV: begin
                    r_quo <= {r_quo[23:0], w_ge};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 5'd1;
                end
                S_NORM: begin
                    ret  <= w_ret_n;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: captured operations push expected results,
// a monitor pops and compares on every done pulse.
`default_nettype none

module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        busy;
    logic        done;
    logic [31:0] ret;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] drv_exp;
    logic [31:0] exp_q[$];
    int          cap_q[$];
    bit          hold_mode = 1'b0;
    int          last_done = -1;

    fp_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a0    (a0),
        .b0    (b0),
        .busy  (busy),
        .done  (done),
        .ret   (ret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: mantissa quotient as a plain integer division scaled by 2^24.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] num;
        logic [47:0] den;
        logic [47:0] quo;
        logic [22:0] fr;
        logic [31:0] ev;
        int          e;
        logic        s;
        s   = a[31] ^ b[31];
        num = {1'b1, a[22:0], 24'h0};
        den = {24'h0, 1'b1, b[22:0]};
        quo = num / den;
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (quo[24]) begin
            fr = quo[23:1];
        end else begin
            fr = quo[22:0];
            e  = e - 1;
        end
        ev = e;
`ifdef FP_DIV_SPECIAL_EN
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        if (a[30:23] == 8'h00) return {s, 31'h0};
        if (b[30:23] == 8'h00) return {s, 8'hFF, 23'h0};
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
`endif
        return {s, ev[7:0], fr};
    endfunction

    // Capture bookkeeping: an accepted start pushes the driver's expectation.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            cap_q.delete();
        end else if (start && !busy) begin
            exp_q.push_back(drv_exp);
            cap_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                chk("ret", ret, exp_q.pop_front());
                chk("latency", 32'(cyc - cap_q.pop_front()), 32'd26);
                chk("busy_in_done", {31'h0, busy}, 32'h0);
            end
            if (hold_mode && last_done >= 0)
                chk("b2b_gap", 32'(cyc - last_done), 32'd27);
            last_done = cyc;
        end else if (!rst && cap_q.size() != 0) begin
            chk("busy_during_op", {31'h0, busy}, 32'h1);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int n;
        @(negedge clk);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'h1, 32'h0);
        a0      = a;
        b0      = b;
        drv_exp = e;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a0    = $urandom;
        b0    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst     = 1'b1;
        start   = 1'b0;
        a0      = 32'h0;
        b0      = 32'h0;
        drv_exp = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_ret", ret, 32'h0);
        rst = 1'b0;

        issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        issue(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000);
        issue(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000);
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
        drain();

        // Start held high with operands changing mid-operation.
        hold_mode = 1'b1;
        last_done = -1;
        @(negedge clk);
        for (int i = 0; i < 27 * 3 + 2; i++) begin
            if (i % 9 == 0) begin
                ra = $urandom;
                rb = $urandom;
                a0 = ra;
                b0 = rb;
                drv_exp = model(ra, rb);
            end
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        hold_mode = 1'b0;

        // Abort in the middle of the iteration.
        issue(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_ret", ret, 32'h0);
        repeat (30) @(negedge clk);
        issue(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000);
        drain();

`ifdef FP_DIV_SPECIAL_EN
        issue(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        issue(32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
        issue(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
        issue(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000);
        drain();
`endif

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue(ra, rb, model(ra, rb));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
